// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Single-outstanding data-memory responder with a configurable wait-state
//   count. A request is accepted in IDLE. The responder then spends
//   WAIT_CYCLES cycles in WAIT and one cycle in RESP, where it presents the
//   response. Internal storage is 2**DEPTH_LOG2 x 32-bit little-endian words.
//   Upper address bits alias onto the storage.
//
// Parameters
//   WAIT_CYCLES  extra wait cycles between accept and response (0..15)
//   DEPTH_LOG2   log2 of the storage word count
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    request present
//   req_ready    responder idle and able to accept
//   addr         byte address
//   mem_read     000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu
//   mem_write    00 none, 01 sw, 10 sh, 11 sb
//   wdata        right-aligned store data
//   rsp_valid    one-cycle response pulse
//   rdata        extended load data (0 outside RESP)
//   rsp_exc      request faulted (0 outside RESP)
//   rsp_exccode  4 AdEL, 5 AdES, 10 RI, else 0
//
// Build option
//   DMEM_MISALIGN_EXC_EN  misaligned lw/lh/lhu fault with AdEL, and misaligned
//                         sw/sh fault with AdES. When the macro is undefined,
//                         misaligned low address bits are cleared and the
//                         access is performed.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_exc,
    output logic [4:0]  rsp_exccode
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LW   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LHU  = 3'b011;
    localparam logic [2:0] LD_LB   = 3'b100;
    localparam logic [2:0] LD_LBU  = 3'b101;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SW   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SB   = 2'b11;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, next_state;

    logic [3:0]  wait_cnt;
    logic [31:0] addr_q;
    logic [2:0]  rd_q;
    logic [1:0]  wr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [0:WORDS-1];

    logic        accept;
    logic        enter_resp;
    logic [31:0] cur_addr;
    logic [2:0]  cur_rd;
    logic [1:0]  cur_wr;
    logic [31:0] cur_wdata;

    logic        is_load;
    logic        is_store;
    logic        illegal;
    logic        fault;
    logic [4:0]  fault_code;
    logic [31:0] eff_addr;
    logic [1:0]  lane;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] resp_rdata;
    logic [3:0]  wr_be;
    logic [31:0] wr_word;
    logic        mem_we;
    logic        unused_addr_bits;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_resp = (next_state == RESP) && (state != RESP);

    // With WAIT_CYCLES=0 the response is formed on the accept edge itself,
    // before the captured copy exists, so the live inputs are decoded in IDLE.
    always_comb begin
        cur_addr  = addr_q;
        cur_rd    = rd_q;
        cur_wr    = wr_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_addr  = addr;
            cur_rd    = mem_read;
            cur_wr    = mem_write;
            cur_wdata = wdata;
        end
    end

    // Request decode, fault classification and effective address.
    always_comb begin
        is_load    = (cur_rd != LD_NONE);
        is_store   = (cur_wr != ST_NONE);
        illegal    = (is_load && is_store) || (cur_rd == 3'b110) || (cur_rd == 3'b111);
        fault      = 1'b0;
        fault_code = '0;
        eff_addr   = cur_addr;

        if (cur_rd == LD_LW || cur_wr == ST_SW) begin
            eff_addr[1:0] = 2'b00;
        end else if (cur_rd == LD_LH || cur_rd == LD_LHU || cur_wr == ST_SH) begin
            eff_addr[0] = 1'b0;
        end

        if (illegal) begin
            fault      = 1'b1;
            fault_code = EXC_RI;
        end
`ifdef DMEM_MISALIGN_EXC_EN
        else if ((cur_rd == LD_LW && cur_addr[1:0] != 2'b00) ||
                 ((cur_rd == LD_LH || cur_rd == LD_LHU) && cur_addr[0])) begin
            fault      = 1'b1;
            fault_code = EXC_ADEL;
        end else if ((cur_wr == ST_SW && cur_addr[1:0] != 2'b00) ||
                     (cur_wr == ST_SH && cur_addr[0])) begin
            fault      = 1'b1;
            fault_code = EXC_ADES;
        end
`endif
    end

    assign lane             = eff_addr[1:0];
    assign idx              = eff_addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^eff_addr[31:DEPTH_LOG2+2];

    // Load path: lane select and sign or zero extension.
    always_comb begin
        rd_word   = mem[idx];
        rd_shift  = rd_word >> {lane, 3'b000};
        rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        case (cur_rd)
            LD_LW:   load_data = rd_word;
            LD_LH:   load_data = {{16{rd_half[15]}}, rd_half};
            LD_LHU:  load_data = {16'h0000, rd_half};
            LD_LB:   load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            LD_LBU:  load_data = {24'h000000, rd_shift[7:0]};
            default: load_data = '0;
        endcase
        resp_rdata = fault ? '0 : load_data;
    end

    // Store path: replicate the data across lanes and enable only the target
    // lane or lanes.
    always_comb begin
        wr_be   = '0;
        wr_word = '0;
        case (cur_wr)
            ST_SW: begin
                wr_be   = 4'b1111;
                wr_word = cur_wdata;
            end
            ST_SH: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{cur_wdata[15:0]}};
            end
            ST_SB: begin
                wr_be   = 4'b0001 << lane;
                wr_word = {4{cur_wdata[7:0]}};
            end
            default: begin
                wr_be   = '0;
                wr_word = '0;
            end
        endcase
    end

    assign mem_we = enter_resp && is_store && !fault;

    // Storage is deliberately left unreset. The rst gate keeps an accept that
    // races a reset assertion from committing a store.
    always_ff @(posedge clk) begin
        if (mem_we && rst) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
            rsp_exc     <= 1'b0;
            rsp_exccode <= '0;
        end else begin
            state <= next_state;

            if (accept) begin
                addr_q  <= addr;
                rd_q    <= mem_read;
                wr_q    <= mem_write;
                wdata_q <= wdata;
            end

            if (state == WAIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end

            // The response registers hold values only during RESP and read zero
            // at all other times.
            if (enter_resp) begin
                rdata       <= resp_rdata;
                rsp_exc     <= fault;
                rsp_exccode <= fault_code;
            end else begin
                rdata       <= '0;
                rsp_exc     <= 1'b0;
                rsp_exccode <= '0;
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of extra wait cycles between accept and response (0..15).
REQ-002 Parameter DEPTH_LOG2, default 10, log2 of word count of internal storage (1024 x 32 b = 4 KiB).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 addr  input  32  byte address.
REQ-008 mem_read  input  3  load type: 000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu; 110/111 illegal.
REQ-009 mem_write  input  2  store type: 00 none, 01 sw, 10 sh, 11 sb.
REQ-010 wdata  input  32  store data, right-aligned (sh uses [15:0], sb uses [7:0]).
REQ-011 rsp_valid  output  1  one-cycle pulse: response present.
REQ-012 rdata  output  32  extended load data; valid only with rsp_valid.
REQ-013 rsp_exc  output  1  request faulted; valid only with rsp_valid.
REQ-014 rsp_exccode  output  5  MIPS ExcCode for the fault: 4 AdEL, 5 AdES, 10 RI; 0 when rsp_exc=0.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-016 Accept = req_valid & req_ready; addr, mem_read, mem_write, wdata captured at accept; later input changes ignored.
REQ-017 IDLE->WAIT on accept when WAIT_CYCLES>0, IDLE->RESP when WAIT_CYCLES=0; WAIT counts WAIT_CYCLES cycles then ->RESP; RESP->IDLE unconditionally.
REQ-018 rsp_valid high exactly during RESP; latency accept-edge to rsp_valid = WAIT_CYCLES+1 cycles; back-to-back requests accepted at most every WAIT_CYCLES+2 cycles.
REQ-019 Storage indexed by addr[DEPTH_LOG2+1:2]; upper address bits ignored (aliasing wrap-around).
REQ-020 Little-endian byte lanes: lane = addr[1:0]; sh writes lanes {addr[1],0..1}, sb writes lane addr[1:0]; other lanes unchanged.
REQ-021 Store committed on the edge entering RESP; a read in the same request sees pre-store contents never (stores return rdata=0).
REQ-022 Loads: lb/lh sign-extend, lbu/lhu zero-extend selected lane(s) to 32 b; lw returns whole word.
REQ-023 mem_read=000 and mem_write=00: accepted as no-op, rsp_valid pulses, rdata=0, rsp_exc=0.
REQ-024 Both mem_read and mem_write nonzero, or mem_read 110/111: no storage change, rsp_exc=1, rsp_exccode=10, rdata=0.
REQ-025 rdata, rsp_exc, rsp_exccode held 0 outside RESP.

Reset
REQ-026 rst low forces IDLE, wait counter 0, req_ready=1, rsp_valid=0, rdata=0, rsp_exc=0, rsp_exccode=0, independent of clk.
REQ-027 Storage contents not reset; reset during WAIT drops the pending request, no store committed, no response issued.

Configuration
REQ-028 Macro DMEM_MISALIGN_EXC_EN defined: lw/lh/lhu with addr misaligned (word: addr[1:0]!=0, half: addr[0]!=0) respond rsp_exc=1, code 4; sw/sh misaligned respond rsp_exc=1, code 5; no storage change, rdata=0.
REQ-029 Macro undefined: misaligned low bits silently cleared (word: [1:0], half: [0]) and the access performed; AdEL/AdES never reported; REQ-024 still applies.

Verification
REQ-030 WAIT_CYCLES=1: sw addr 0x10 wdata 0xDEADBEEF, then lw 0x10 -> rsp_valid 2 cycles after each accept, rdata=0xDEADBEEF, req_ready low 2 cycles per request.
REQ-031 After REQ-030: sb addr 0x11 wdata 0x80; lb 0x11 -> 0xFFFFFF80; lbu 0x11 -> 0x00000080; lw 0x10 -> 0xDEAD80EF.
REQ-032 lh 0x12 -> 0xFFFFDEAD; lhu 0x12 -> 0x0000DEAD; lw 0x1010 (DEPTH_LOG2=10) -> 0xDEAD80EF (alias).
REQ-033 With DMEM_MISALIGN_EXC_EN: lw 0x13 -> rsp_exc=1, code 4; sh 0x11 -> code 5, lw 0x10 still 0xDEAD80EF; without macro: lw 0x13 -> 0xDEAD80EF, rsp_exc=0.
REQ-034 mem_read=001 with mem_write=01 -> rsp_exc=1, code 10, storage unchanged; mem_read=111 -> code 10.
REQ-035 Assert rst low during WAIT of sw 0x20 wdata 0x12345678 -> outputs zero immediately, no rsp_valid; after release lw 0x20 returns prior contents.
